// File: rtl/sauria_cfg_router.sv
// Single-outstanding request router from the AXI-Lite front-end to REGS/SRAMA/SRAMB/SRAMC.
// Optional target timeout enabled by defining SAURIA_CFG_ROUTER_TIMEOUT_EN.
module sauria_cfg_router #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [31:0]           i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [DATA_W/8-1:0]   i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic [1:0]            o_rsp_err,
  output logic [3:0]            o_tgt_req,
  output logic                  o_tgt_we,
  output logic [17:0]           o_tgt_addr,
  output logic [DATA_W-1:0]     o_tgt_wdata,
  output logic [DATA_W/8-1:0]   o_tgt_be,
  input  logic [3:0]            i_tgt_gnt,
  input  logic [3:0]            i_tgt_rvalid,
  input  logic [4*DATA_W-1:0]   i_tgt_rdata
);

  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_ERR} state_t;

  if (TIMEOUT_CYC < 2) begin : g_param_check
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t              state_q, state_d;
  logic [1:0]          tgt_idx_q;
  logic                dec_hit;
  logic                sel_gnt, sel_rvalid;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout;
  logic                done_ok, done_tmo;

  // Region 0 only maps the five 512-byte register windows (0x000-0x9FF).
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    dec_hit = 1'b0;
    if (i_req_addr[31:22] == '0) begin
      case (i_req_addr[21:18])
        4'd0:              dec_hit = (i_req_addr[17:12] == '0) && (i_req_addr[11:9] <= 3'd4);
        4'd1, 4'd2, 4'd3:  dec_hit = 1'b1;
        default:           dec_hit = 1'b0;
      endcase
    end
  end

  assign sel_gnt    = i_tgt_gnt[tgt_idx_q];
  assign sel_rvalid = i_tgt_rvalid[tgt_idx_q];
  assign sel_rdata  = i_tgt_rdata[tgt_idx_q*DATA_W +: DATA_W];

`ifdef SAURIA_CFG_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Counts cycles spent in ISSUE+WAIT; zero on entry to ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst || !(state_q inside {ST_ISSUE, ST_WAIT}))
      tmo_cnt_q <= '0;
    else
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  assign timeout = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // A response in the timeout cycle still wins and returns OKAY.
  assign done_ok  = ((state_q == ST_ISSUE) && sel_gnt && sel_rvalid) ||
                    ((state_q == ST_WAIT) && sel_rvalid);
  assign done_tmo = (state_q inside {ST_ISSUE, ST_WAIT}) && timeout && !done_ok;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_req_valid) state_d = dec_hit ? ST_ISSUE : ST_ERR;
      ST_ISSUE: begin
        if (done_ok || done_tmo) state_d = ST_RESP;
        else if (sel_gnt)        state_d = ST_WAIT;
      end
      ST_WAIT:  if (done_ok || done_tmo) state_d = ST_RESP;
      ST_ERR:   state_d = ST_RESP;
      ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_rsp_valid = (state_q == ST_RESP);
    o_tgt_req   = (state_q == ST_ISSUE) ? (4'b0001 << tgt_idx_q) : 4'b0000;
  end

  // Target-side fields only load for mapped requests so unmapped traffic never reaches a target.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tgt_idx_q   <= '0;
      o_tgt_we    <= 1'b0;
      o_tgt_addr  <= '0;
      o_tgt_wdata <= '0;
      o_tgt_be    <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= RSP_OKAY;
    end else begin
      if ((state_q == ST_IDLE) && i_req_valid) begin
        o_rsp_rdata <= '0;
        o_rsp_err   <= RSP_OKAY;
        if (dec_hit) begin
          tgt_idx_q   <= i_req_addr[19:18];
          o_tgt_we    <= i_req_we;
          o_tgt_addr  <= i_req_addr[17:0];
          o_tgt_wdata <= i_req_wdata;
          o_tgt_be    <= i_req_be;
        end
      end
      if (done_ok) begin
        o_rsp_rdata <= o_tgt_we ? '0 : sel_rdata;
        o_rsp_err   <= RSP_OKAY;
      end else if (done_tmo) begin
        o_rsp_rdata <= '0;
        o_rsp_err   <= RSP_SLVERR;
      end
      if (state_q == ST_ERR) begin
        o_rsp_rdata <= '0;
        o_rsp_err   <= RSP_DECERR;
      end
    end
  end

endmodule

// File: tb/tb_sauria_cfg_router.sv
// Self-checking bench for sauria_cfg_router: directed test-plan steps plus randomized traffic
// checked against an address-map model. Timeout step runs when SAURIA_CFG_ROUTER_TIMEOUT_EN is defined.
module tb_sauria_cfg_router;
  localparam int DATA_W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid, i_req_we, i_rsp_ready;
  logic [31:0]   i_req_addr, i_req_wdata;
  logic [3:0]    i_req_be;
  logic          o_req_ready, o_rsp_valid, o_tgt_we;
  logic [31:0]   o_rsp_rdata, o_tgt_wdata;
  logic [1:0]    o_rsp_err;
  logic [3:0]    o_tgt_req, o_tgt_be, i_tgt_gnt, i_tgt_rvalid;
  logic [17:0]   o_tgt_addr;
  logic [127:0]  i_tgt_rdata;

  int errors = 0;
  int checks = 0;

  sauria_cfg_router #(.DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_tgt_req(o_tgt_req), .o_tgt_we(o_tgt_we),
    .o_tgt_wdata(o_tgt_wdata), .o_tgt_be(o_tgt_be), .o_tgt_addr(o_tgt_addr),
    .i_tgt_gnt(i_tgt_gnt), .i_tgt_rvalid(i_tgt_rvalid), .i_tgt_rdata(i_tgt_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Address map as plain arithmetic: returns target index, or -1 for DECERR.
  function automatic int model_target(input logic [31:0] addr);
    int unsigned a, region, off;
    a = addr;
    if (a >= 32'h0040_0000) return -1;
    region = a / 32'h0004_0000;
    off    = a % 32'h0004_0000;
    if (region == 0) return (off < 32'h0000_0A00) ? 0 : -1;
    if (region <= 3) return int'(region);
    return -1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"}, o_req_ready, 1);
    check({tag, ".rsp_valid"}, o_rsp_valid, 0);
    check({tag, ".rsp_rdata"}, o_rsp_rdata, 0);
    check({tag, ".rsp_err"},   o_rsp_err, 0);
    check({tag, ".tgt_req"},   o_tgt_req, 0);
    check({tag, ".tgt_we"},    o_tgt_we, 0);
    check({tag, ".tgt_addr"},  o_tgt_addr, 0);
    check({tag, ".tgt_wdata"}, o_tgt_wdata, 0);
    check({tag, ".tgt_be"},    o_tgt_be, 0);
  endtask

  // Drives one full transaction starting and ending just after a falling edge.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int gnt_dly,
                        input int rsp_dly, input logic [31:0] rdata, input int bp);
    int t;
    logic [3:0]  oh;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    t = model_target(addr);
    check({tag, ".accept_ready"}, o_req_ready, 1);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_be = be;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom; i_req_we = ~we;
    if (t < 0) begin
      check({tag, ".err_tgt_req"}, o_tgt_req, 0);
      check({tag, ".err_early_valid"}, o_rsp_valid, 0);
      @(negedge i_clk);
      exp_err = 2'b11; exp_rdata = '0;
    end else begin
      oh = 4'b0001 << t;
      for (int c = 0; c <= gnt_dly; c++) begin
        check({tag, ".tgt_req"}, o_tgt_req, oh);
        check({tag, ".busy_ready"}, o_req_ready, 0);
        check({tag, ".early_valid"}, o_rsp_valid, 0);
        i_tgt_rvalid = 4'($urandom) & ~oh;
        i_tgt_rdata  = {$urandom, $urandom, $urandom, $urandom};
        if (c == gnt_dly) begin
          check({tag, ".tgt_addr"},  o_tgt_addr, addr & 32'h3FFFF);
          check({tag, ".tgt_we"},    o_tgt_we, we);
          check({tag, ".tgt_wdata"}, o_tgt_wdata, wdata);
          check({tag, ".tgt_be"},    o_tgt_be, be);
          i_tgt_gnt = oh | (4'($urandom) & ~oh);
          if (rsp_dly == 0) begin
            i_tgt_rvalid = i_tgt_rvalid | oh;
            i_tgt_rdata[t*32 +: 32] = rdata;
          end
        end else begin
          i_tgt_gnt = 4'($urandom) & ~oh;
        end
        @(negedge i_clk);
        i_tgt_gnt = '0; i_tgt_rvalid = '0;
      end
      for (int c = 1; c <= rsp_dly; c++) begin
        check({tag, ".wait_tgt_req"}, o_tgt_req, 0);
        check({tag, ".wait_valid"}, o_rsp_valid, 0);
        i_tgt_rvalid = 4'($urandom) & ~oh;
        i_tgt_gnt    = 4'($urandom);
        i_tgt_rdata  = {$urandom, $urandom, $urandom, $urandom};
        if (c == rsp_dly) begin
          i_tgt_rvalid = i_tgt_rvalid | oh;
          i_tgt_rdata[t*32 +: 32] = rdata;
        end
        @(negedge i_clk);
        i_tgt_gnt = '0; i_tgt_rvalid = '0;
      end
      exp_err = 2'b00; exp_rdata = we ? 32'h0 : rdata;
    end
    check({tag, ".rsp_valid"}, o_rsp_valid, 1);
    check({tag, ".rsp_rdata"}, o_rsp_rdata, exp_rdata);
    check({tag, ".rsp_err"},   o_rsp_err, exp_err);
    check({tag, ".rsp_tgt_req"}, o_tgt_req, 0);
    for (int b = 0; b < bp; b++) begin
      @(negedge i_clk);
      check({tag, ".bp_valid"}, o_rsp_valid, 1);
      check({tag, ".bp_rdata"}, o_rsp_rdata, exp_rdata);
      check({tag, ".bp_err"},   o_rsp_err, exp_err);
      check({tag, ".bp_ready"}, o_req_ready, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    check({tag, ".done_valid"}, o_rsp_valid, 0);
    check({tag, ".done_ready"}, o_req_ready, 1);
  endtask

  initial begin
    logic [31:0] addr;
    int unsigned hi;
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_be = '0; i_rsp_ready = 1'b0; i_tgt_gnt = '0; i_tgt_rvalid = '0; i_tgt_rdata = '0;
    repeat (2) @(negedge i_clk);
    check_reset_values("reset");
    i_rst = 1'b0;

    do_txn("rd_srama", 1'b0, 32'h0004_0010, 32'h0, 4'hF, 0, 3, 32'hDEAD_BEEF, 0);
    do_txn("wr_regs",  1'b1, 32'h0000_0604, 32'h1234_5678, 4'hF, 4, 1, 32'hCAFE_F00D, 0);
    do_txn("dec_region4", 1'b0, 32'h0010_0000, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    do_txn("dec_regs_a00", 1'b1, 32'h0000_0A00, 32'h5555_AAAA, 4'h3, 0, 0, 32'h0, 0);
    do_txn("dec_high", 1'b0, 32'h0040_0000, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    do_txn("regs_last", 1'b0, 32'h0000_09FC, 32'h0, 4'hF, 0, 0, 32'h0BAD_1DEA, 0);
    do_txn("bp_sramb", 1'b0, 32'h0008_1234, 32'h0, 4'hF, 0, 0, 32'hA5A5_5A5A, 10);
    do_txn("after_bp", 1'b1, 32'h000C_3FFC, 32'hFEED_0001, 4'h8, 1, 2, 32'h1111_2222, 0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       addr = 32'($urandom_range(0, 32'h9FF));
        1:       addr = 32'($urandom_range(32'hA00, 32'h3FFFF));
        2, 5:    addr = (32'($urandom_range(1, 3)) << 18) | 32'($urandom_range(0, 32'h3FFFF));
        3:       addr = (32'($urandom_range(4, 15)) << 18) | 32'($urandom_range(0, 32'h3FFFF));
        default: begin
          hi   = $urandom_range(1, 1023);
          addr = (32'(hi) << 22) | ($urandom & 32'h003F_FFFF);
        end
      endcase
      do_txn($sformatf("rand%0d", n), 1'($urandom), addr, $urandom, 4'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom_range(0, 3));
    end

    // Reset while a SRAMB read sits in WAIT.
    check("rst.accept_ready", o_req_ready, 1);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0008_0100;
    i_req_wdata = 32'h7777_8888; i_req_be = 4'hF;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("rst.tgt_req", o_tgt_req, 4'b0100);
    i_tgt_gnt = 4'b0100;
    @(negedge i_clk);
    i_tgt_gnt = '0;
    check("rst.wait_valid", o_rsp_valid, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check_reset_values("rst_mid");
    i_tgt_rvalid = 4'b0100; i_tgt_rdata = {4{32'h9999_0000}};
    @(negedge i_clk);
    i_tgt_rvalid = '0;
    check("rst.late_valid", o_rsp_valid, 0);
    check("rst.late_ready", o_req_ready, 1);
    check("rst.late_rdata", o_rsp_rdata, 0);
    do_txn("rd_sramb_after_rst", 1'b0, 32'h0008_0200, 32'h0, 4'hF, 1, 1, 32'h0123_4567, 0);

`ifdef SAURIA_CFG_ROUTER_TIMEOUT_EN
    // SRAMC never answers: sixteen cycles in ISSUE, then SLVERR.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h000C_0040; i_req_be = 4'hF;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("tmo.tgt_req", o_tgt_req, 4'b1000);
      check("tmo.early_valid", o_rsp_valid, 0);
      @(negedge i_clk);
    end
    check("tmo.rsp_valid", o_rsp_valid, 1);
    check("tmo.rsp_err", o_rsp_err, 2'b10);
    check("tmo.rsp_rdata", o_rsp_rdata, 0);
    check("tmo.tgt_req_dropped", o_tgt_req, 0);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    i_tgt_rvalid = 4'b1000;
    @(negedge i_clk);
    i_tgt_rvalid = '0;
    check("tmo.late_valid", o_rsp_valid, 0);
    check("tmo.late_ready", o_req_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sauria_cfg_router.md
# sauria_cfg_router

Single-outstanding request router that sits directly downstream of the SAURIA AXI-Lite slave front-end and upstream of the SAURIA internal targets: configuration registers, SRAMA, SRAMB and SRAMC. It decodes each 32-bit request address against the fixed SAURIA internal address map, then issues the request on a one-hot target port. It collects the target's response and returns it upstream with an AXI-style error code. Unmapped addresses complete locally with DECERR and never touch a target.

## Interface
- `DATA_W`, 32, data width of request, response and target buses.
- `TIMEOUT_CYC`, 256, cycles to wait for a target grant or response before aborting. Only used with the timeout feature; must be ≥ 2.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_req_valid`  in  1  upstream request valid.
- `o_req_ready`  out  1  upstream request accepted.
- `i_req_we`  in  1  1 = write, 0 = read.
- `i_req_addr`  in  32  byte address, SAURIA internal space.
- `i_req_wdata`  in  DATA_W  write data.
- `i_req_be`  in  DATA_W/8  byte enables.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  upstream accepts response.
- `o_rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `o_rsp_err`  out  2  response code: 00 OKAY, 10 SLVERR, 11 DECERR.
- `o_tgt_req`  out  4  one-hot target request. Bit 0 REGS, bit 1 SRAMA, bit 2 SRAMB, bit 3 SRAMC.
- `o_tgt_we`, `o_tgt_wdata`, `o_tgt_be`  out  1/DATA_W/DATA_W/8  registered copies of the request.
- `o_tgt_addr`  out  18  `i_req_addr[17:0]`, local offset within the region.
- `i_tgt_gnt`  in  4  per-target grant.
- `i_tgt_rvalid`  in  4  per-target response valid, one cycle pulse.
- `i_tgt_rdata`  in  4*DATA_W  per-target read data; target k occupies `[k*DATA_W +: DATA_W]`.

## Operation
- Decode uses `i_req_addr[21:18]`, the memory field (mask 0x003C_0000):
  - 0 → REGS, but only if `i_req_addr[11:9]` ≤ 4 and `i_req_addr[31:22]` = 0 and `[17:12]` = 0. This covers CFG regs, CON, ACT, WEI and OUT at 0x000–0x9FF.
  - 1 → SRAMA; 2 → SRAMB; 3 → SRAMC. Each requires `[31:22]` = 0.
  - Anything else → DECERR.
- The FSM has five states: IDLE, ISSUE, WAIT, RESP, ERR.
  - IDLE: `o_req_ready`=1. On `i_req_valid`, the block registers the request and decoded target.
    - Mapped address → ISSUE.
    - Unmapped address → ERR.
  - ISSUE: `o_tgt_req` drives the target's one-hot bit. When the selected `i_tgt_gnt`=1, the block drops the request and goes to WAIT. If the selected `i_tgt_rvalid` arrives in the same cycle as the grant, it goes straight to RESP.
  - WAIT: on the selected `i_tgt_rvalid`, the block latches data (reads) or 0 (writes) with err=00, then → RESP.
  - ERR: loads err=11, rdata=0, then → RESP.
  - RESP: `o_rsp_valid`=1 and outputs are held stable. On `i_rsp_ready` → IDLE.
- `i_tgt_gnt` and `i_tgt_rvalid` bits of non-selected targets are ignored.
- Exactly one transaction is outstanding at any time. `o_req_ready` is 0 in every state except IDLE.

## Timing
- Reset values:
  - FSM = IDLE; `o_req_ready`=1 (combinational from state).
  - `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=00.
  - `o_tgt_req`=0, `o_tgt_we`=0, `o_tgt_addr`=0, `o_tgt_wdata`=0, `o_tgt_be`=0.
- Reset asserted mid-transaction returns the block to IDLE on the next edge and drops any pending target request or response. A late target `rvalid` that arrives in IDLE is ignored.
- `o_tgt_req` is registered and asserts the cycle after acceptance.
- Mapped-request latency, with grant and rvalid in the same cycle as the request: accept edge → ISSUE → RESP. `o_rsp_valid` is high 2 cycles after the accept cycle.
- DECERR latency: `o_rsp_valid` is high 2 cycles after acceptance (IDLE → ERR → RESP).
- Back-to-back throughput is at most one transaction per 3 cycles.

## Configuration
- Macro: `SAURIA_CFG_ROUTER_TIMEOUT_EN`.
- Defined: a counter clears on entry to ISSUE and counts cycles spent in ISSUE+WAIT. On reaching `TIMEOUT_CYC`, the block drops `o_tgt_req` and goes to RESP with err=10 and rdata=0. The counter width is `$clog2(TIMEOUT_CYC+1)`. An `rvalid` arriving in the same cycle as the timeout wins and returns OKAY.
- Undefined: no counter exists and the block waits indefinitely in ISSUE/WAIT. `TIMEOUT_CYC` is unused.

## Test plan
- Read 0x0004_0010, SRAMA grants immediately, rvalid 3 cycles later with 0xDEADBEEF:
  - `o_tgt_req`=4'b0010 and `o_tgt_addr`=0x00010.
  - Response rdata 0xDEADBEEF, err 00.
- Write 0x0000_0604, data 0x12345678, be 0xF, to REGS with the grant delayed 5 cycles:
  - `o_tgt_req`=4'b0001 is held for 5 cycles.
  - Response err 00, rdata 0.
- Accesses to 0x0010_0000, 0x0000_0A00 and 0x0040_0000:
  - Each gets err 11 with `o_rsp_valid` 2 cycles after acceptance.
  - `o_tgt_req` stays 0 throughout.
- Response backpressure: `i_rsp_ready`=0 for 10 cycles.
  - `o_rsp_valid`, rdata and err remain stable.
  - `o_req_ready`=0 until the handshake, after which the next request is accepted.
- With `SAURIA_CFG_ROUTER_TIMEOUT_EN` and `TIMEOUT_CYC`=16, SRAMC never responds:
  - Response err 10 after 16 cycles in ISSUE/WAIT.
  - A late `rvalid` in IDLE is ignored.
- Assert `i_rst` while in WAIT:
  - Next cycle, all outputs are at their reset values.
  - A subsequent SRAMB read completes normally.
